// File: rtl/seq_multiplier_32bit_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: FSM state encoding
// and the index of the final shift-and-add iteration.
package seq_multiplier_32bit_pkg;

    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_32bit.sv
// 32-bit ripple-carry adder built from a chain of one-bit full adders.
// The final carry is not exported; consumers derive it from the operand and sum MSBs.
module full_adder_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum
);

    logic [31:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry[i];
        if (i < 31) begin : g_carry
            assign w_carry[i+1] = (i_a[i] & i_b[i]) | ((i_a[i] ^ i_b[i]) & w_carry[i]);
        end
    end

endmodule

// File: rtl/seq_multiplier_32bit.sv
// Unsigned 32x32->64 shift-and-add multiplier: one ripple-adder pass per clock,
// 32 iterations per product, launched and collected with a start/busy/done handshake.
module seq_multiplier_32bit
    import seq_multiplier_32bit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    state_t           r_state;
    state_t           w_stateNext;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_pHi;
    logic [WIDTH-1:0] r_pLo;
    logic [4:0]       r_count;
    logic [WIDTH-1:0] w_addB;
    logic [WIDTH-1:0] w_sum;
    logic             w_carryOut;

    assign w_addB = r_pLo[0] ? r_m : '0;

    full_adder_32bit u_adder (
        .i_a   (r_pHi),
        .i_b   (w_addB),
        .i_cin (1'b0),
        .o_sum (w_sum)
    );

    // The adder hides its carry, so recover it from the MSBs of the operands and sum.
    assign w_carryOut = (r_pHi[WIDTH-1] & w_addB[WIDTH-1])
                      | ((r_pHi[WIDTH-1] ^ w_addB[WIDTH-1]) & ~w_sum[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_stateNext = S_RUN;
            S_RUN:   if (r_count == ITER_LAST) w_stateNext = S_DONE;
            S_DONE:  w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m     <= '0;
            r_pHi   <= '0;
            r_pLo   <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_m     <= i_multiplicand;
                        r_pHi   <= '0;
                        r_pLo   <= i_multiplier;
                        r_count <= '0;
                    end
                end
                S_RUN: begin
                    // Shift the 65-bit {carry, sum, P_lo} right by one into {P_hi, P_lo}.
                    r_pHi   <= {w_carryOut, w_sum[WIDTH-1:1]};
                    r_pLo   <= {w_sum[0], r_pLo[WIDTH-1:1]};
                    r_count <= r_count + 5'd1;
                end
                default: ;
            endcase
        end
    end

    assign o_busy    = (r_state == S_RUN);
    assign o_done    = (r_state == S_DONE);
    assign o_product = {r_pHi, r_pLo};

endmodule

// File: tb/tb_seq_multiplier_32bit.sv
// Scoreboard bench for seq_multiplier_32bit: directed operand pairs push expected
// products and done cycles; a negedge monitor pops and compares on every done pulse.
module tb_seq_multiplier_32bit;

    typedef struct {
        logic [63:0] product;
        int          doneCycle;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;

    exp_t sbQueue[$];
    int   cycleNo;
    int   vectorCount;
    int   errorCount;

    seq_multiplier_32bit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_multiplicand (multiplicand),
        .i_multiplier   (multiplier),
        .o_busy         (busy),
        .o_done         (done),
        .o_product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycleNo = 0;
    always @(posedge clk) cycleNo <= cycleNo + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, wanted %h (cycle %0d)", name, actual, expected, cycleNo);
        end
    endtask

    // Launch one multiplication; the accepting edge is the next posedge.
    task automatic applyStimulus(input logic [31:0] m, input logic [31:0] q,
                                 input logic [63:0] expected, input bit track);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        if (track) sbQueue.push_back('{expected, cycleNo + 1 + 32});
        @(negedge clk);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic waitDone();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("doneSeen", {63'd0, seen}, 64'd1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy && done) checkOutput("busyDoneExclusive", 64'd1, 64'd0);
            if (done) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedDone", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sbQueue.pop_front();
                    checkOutput("product", product, e.product);
                    checkOutput("doneCycle", 64'(cycleNo), 64'(e.doneCycle));
                end
            end
        end
    end

    initial begin
        int base;
        int doneCount;
        vectorCount  = 0;
        errorCount   = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        #1;
        checkOutput("resetBusy",    {63'd0, busy}, 64'd0);
        checkOutput("resetDone",    {63'd0, done}, 64'd0);
        checkOutput("resetProduct", product,       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        waitDone();

        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        waitDone();

        applyStimulus(32'h1234_5678, 32'd0, 64'd0, 1'b1);
        waitDone();

        applyStimulus(32'd7, 32'd9, 64'd63, 1'b1);
        repeat (8) @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        waitDone();
        repeat (5) @(negedge clk);
        checkOutput("holdProduct", product, 64'd63);
        checkOutput("holdBusy", {63'd0, busy}, 64'd0);

        applyStimulus(32'hABCD_0123, 32'h0000_1234, 64'd0, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abortBusy",    {63'd0, busy}, 64'd0);
        checkOutput("abortDone",    {63'd0, done}, 64'd0);
        checkOutput("abortProduct", product,       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("noDoneAfterAbort", 64'(doneCount), 64'd0);

        applyStimulus(32'd6, 32'd7, 64'd42, 1'b1);
        waitDone();

        // Start held high: acceptances every 34 edges, three in a row.
        @(negedge clk);
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
        base = cycleNo + 1;
        for (int i = 0; i < 3; i++) sbQueue.push_back('{64'd4, base + 34 * i + 32});
        repeat (69) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        checkOutput("scoreboardDrained", 64'(sbQueue.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
